// File: rtl/pe_mac_v2_pkg.sv
// Shared types and arithmetic helpers for the pe_mac_v2 processing element.
// Product width, the tag that travels with each product, and the accumulator add.
package pe_pkg;

    localparam int unsigned ACC_MAX_W = 64;

    function automatic int unsigned PROD_W(input int unsigned data_w);
        return 2 * data_w + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic clear;
        logic is_signed;
    } pe_tag_t;

    typedef struct packed {
        logic signed [ACC_MAX_W-1:0] sum;
        logic                        ovf;
    } sat_res_t;

    // Operands arrive sign-extended to ACC_MAX_W; acc_w is the real accumulator
    // width (<= ACC_MAX_W). On wrap the caller truncates sum to acc_w bits.
    function automatic sat_res_t sat_add(
        input logic signed [ACC_MAX_W-1:0] acc,
        input logic signed [ACC_MAX_W-1:0] prod,
        input int unsigned                 acc_w,
        input logic                        saturate
    );
        logic signed [ACC_MAX_W:0] sum;
        logic signed [ACC_MAX_W:0] lim;
        sat_res_t                  r;
        sum   = (ACC_MAX_W+1)'(acc) + (ACC_MAX_W+1)'(prod);
        lim   = (ACC_MAX_W+1)'(1) <<< (acc_w - 1);
        r.ovf = (sum >= lim) || (sum < -lim);
        if (r.ovf && saturate) begin
            r.sum = sum[ACC_MAX_W] ? ACC_MAX_W'(-lim) : ACC_MAX_W'(lim - 1);
        end else begin
            r.sum = sum[ACC_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_mac_v2_mult_pipe.sv
// Operand extension, multiply and tag pipeline (0, 1 or 2 stages) for pe_mac_v2.
// Maps onto a single DSP slice; the tag rides alongside the product.
module pe_mult_pipe
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MULT_LAT = 1,
    localparam int unsigned PW      = PROD_W(DATA_W)
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_valid,
    input  logic                 i_clear,
    input  logic                 i_signed,
    input  logic [DATA_W-1:0]    i_a,
    input  logic [DATA_W-1:0]    i_b,
    output pe_tag_t              o_tag,
    output logic signed [PW-1:0] o_prod
);

    pe_tag_t tag_in;

    always_comb begin
        tag_in.valid     = i_valid;
        tag_in.clear     = i_valid & i_clear;
        tag_in.is_signed = i_signed;
    end

    function automatic logic signed [PW-1:0] mul_ext(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sgn
    );
        logic signed [DATA_W:0] ax;
        logic signed [DATA_W:0] bx;
        ax = {sgn & a[DATA_W-1], a};
        bx = {sgn & b[DATA_W-1], b};
        return PW'(ax) * PW'(bx);
    endfunction

    generate
        if (MULT_LAT == 0) begin : g_lat0
            logic unused_clk_rst;
            always_comb begin
                unused_clk_rst = i_clk ^ i_arst;
                o_tag          = tag_in;
                o_prod         = mul_ext(i_a, i_b, i_signed);
            end
        end else if (MULT_LAT == 1) begin : g_lat1
            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    o_tag  <= '0;
                    o_prod <= '0;
                end else begin
                    o_tag <= tag_in;
                    if (i_valid) o_prod <= mul_ext(i_a, i_b, i_signed);
                end
            end
        end else begin : g_lat2
            // Raw operands are registered first; extension uses the carried sign tag.
            pe_tag_t           tag1;
            logic [DATA_W-1:0] a1;
            logic [DATA_W-1:0] b1;
            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    tag1   <= '0;
                    a1     <= '0;
                    b1     <= '0;
                    o_tag  <= '0;
                    o_prod <= '0;
                end else begin
                    tag1  <= tag_in;
                    o_tag <= tag1;
                    if (i_valid) begin
                        a1 <= i_a;
                        b1 <= i_b;
                    end
                    if (tag1.valid) o_prod <= mul_ext(a1, b1, tag1.is_signed);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pe_mac_v2.sv
// Output-stationary systolic PE: forwards operands east/south, accumulates
// signed/unsigned products with optional saturation, and unloads via a shift chain.
module pe_mac_v2
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned MULT_LAT = 1,
    parameter int unsigned SATURATE = 1
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_valid,
    input  logic              i_clear,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic              o_valid,
    output logic              o_clear,
    input  logic              i_drain,
    input  logic              i_y_shift,
    input  logic [ACC_W-1:0]  i_y,
    output logic [ACC_W-1:0]  o_y,
    output logic              o_ovf
);

    localparam int unsigned PW = PROD_W(DATA_W);

    pe_tag_t                 pv_tag;
    logic signed [PW-1:0]    pv_prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_next;
    logic                    ovf_q;
    logic                    ovf_next;
    sat_res_t                add_r;
    logic                    unused_sgn;

    pe_mult_pipe #(
        .DATA_W  (DATA_W),
        .MULT_LAT(MULT_LAT)
    ) u_mult (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_valid (i_valid),
        .i_clear (i_clear),
        .i_signed(i_signed),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_tag   (pv_tag),
        .o_prod  (pv_prod)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_a     <= '0;
            o_b     <= '0;
            o_valid <= 1'b0;
            o_clear <= 1'b0;
        end else begin
            o_valid <= i_valid;
            o_clear <= i_valid & i_clear;
            if (i_valid) begin
                o_a <= i_a;
                o_b <= i_b;
            end
        end
    end

    always_comb begin
        unused_sgn = pv_tag.is_signed;
        add_r      = sat_add(ACC_MAX_W'(acc_q), ACC_MAX_W'(pv_prod), ACC_W, SATURATE != 0);
        acc_next   = acc_q;
        ovf_next   = ovf_q;
        if (pv_tag.valid) begin
            if (pv_tag.clear) begin
                acc_next = ACC_W'(pv_prod);
                ovf_next = 1'b0;
            end else begin
                acc_next = ACC_W'(add_r.sum);
                ovf_next = ovf_q | add_r.ovf;
            end
        end
    end

    // Drain captures acc_next so a product landing this cycle is included.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            o_y   <= '0;
        end else begin
            acc_q <= acc_next;
            ovf_q <= ovf_next;
            if (i_drain) begin
                o_y <= acc_next;
            end else if (i_y_shift) begin
                o_y <= i_y;
            end
        end
    end

    always_comb begin
        o_ovf = ovf_q;
    end

endmodule

// File: doc/pe_mac_v2.md
# pe_mac_v2

Parametrised output-stationary processing element for the systolic NPU array, successor to the fixed 8-bit PE. Each tile forwards operands east and south with a valid tag. It accumulates a pipelined signed or unsigned product with optional saturation. Finished results unload through a per-column shift chain, so the array drains without a wide output mux.

## Interface
- DATA_W, 8, operand width in bits
- ACC_W, 32, accumulator and result width; must be ≥ 2*DATA_W+2
- MULT_LAT, 1, multiplier pipeline stages; legal values 0, 1, 2
- SATURATE, 1, 1 = clamp the accumulator on overflow, 0 = wrap
- i_clk  in  1  clock
- i_arst  in  1  reset, asynchronous, active-high
- i_valid  in  1  operands on i_a/i_b are valid this cycle
- i_clear  in  1  qualified by i_valid: this product starts a new tile
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with i_valid
- i_a  in  DATA_W  west operand
- i_b  in  DATA_W  north operand
- o_a  out  DATA_W  registered i_a toward the east neighbour
- o_b  out  DATA_W  registered i_b toward the south neighbour
- o_valid  out  1  registered i_valid
- o_clear  out  1  registered i_valid & i_clear
- i_drain  in  1  load the accumulator into the output register
- i_y_shift  in  1  shift the drain chain by one
- i_y  in  ACC_W  upstream neighbour's o_y
- o_y  out  ACC_W  output shift register
- o_ovf  out  1  sticky overflow flag for the current tile

## Operation
- Forwarding: on i_valid, a_q/b_q load i_a/i_b; otherwise they hold. o_valid/o_clear register every cycle, with no hold.
- Operand extension: each operand extends to DATA_W+1 bits. Sign-extend when i_signed=1, zero-extend when 0. The product is a signed 2*DATA_W+2-bit value.
- Multiply pipe: the product travels with its valid and clear tags through MULT_LAT stages. With MULT_LAT=0 the product is combinational into the accumulator adder.
- Accumulate, on a tagged-valid product at the pipe output (pv):
  - Clear tag: acc ← product sign-extended to ACC_W; ovf ← 0.
  - Otherwise: acc ← acc + product, computed at ACC_W+1 bits.
  - On signed overflow with SATURATE=1: acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and ovf ← 1.
  - On signed overflow with SATURATE=0: acc wraps, and ovf ← 1.
- Idle: with no pv, acc and ovf hold. Removing i_valid does not clear the accumulator.
- Drain chain:
  - i_drain=1: out_q ← acc_next, the value including any product landing this cycle.
  - Else if i_y_shift=1: out_q ← i_y.
  - Else out_q holds.
  - i_drain has priority when both are high. o_y = out_q.
- Mode change: i_signed travels with each product tag, so mixing modes inside a tile is legal, but undefined for the math.

## Timing
- Reset values: every output, acc, ovf and the pipe tags are 0.
- Forward latency: 1 cycle from i_a/i_b/i_valid to o_a/o_b/o_valid.
- Accumulate latency: an operand pair at edge N is in acc after edge N+MULT_LAT+1.
- Drain: one cycle from i_drain to o_y. Each i_y_shift moves the chain one PE.
- Reset mid-tile: reset flushes the pipe. Products in flight are lost and are not accumulated.
- Clear with idle pipe: i_clear with i_valid=0 is ignored.
- Back-to-back tiles: a clear-tagged product in the cycle after the last product of the previous tile is legal. Drain on that last pv cycle captures the complete previous tile.

## Structure
- Package pe_pkg holds:
  - the localparam for product width, PROD_W(DATA_W) = 2*DATA_W+2;
  - the function sat_add(acc, prod) returning sum and overflow;
  - the struct pe_tag_t {valid, clear, is_signed}.
- Sub-module pe_mult_pipe(DATA_W, MULT_LAT) does the operand extension, the multiply and the tag pipeline. It replaces dsp_mult and maps to a DSP slice.
- Top level holds the forwarding registers, accumulator and drain register.

## Test plan
- Reset mid-tile, DATA_W=8, MULT_LAT=2: set up as in scenario 2, then assert reset two cycles after the last pair. Required: o_y=0, o_ovf=0, o_valid=0, and the later drain returns 0.
- Signed dot product, MULT_LAT=1: pairs (3,4) with clear, then (-2,5), (7,-1) -> acc=12-10-7=-5; drain gives o_y=0xFFFFFFFB two cycles after the last pair.
- Unsigned mode: (255,255) with clear, then (255,255) -> acc=130050; drain gives o_y=0x0001FC02.
- Saturation, ACC_W=18, SATURATE=1: signed (-128,-128) repeated 9 times -> acc clamps to 131071 and o_ovf=1. The next clear-tagged (1,1) gives acc=1 and o_ovf=0.
- Drain chain of 3 PEs holding 10, 20, 30: one i_drain, then 3 i_y_shift -> o_y of the last PE reads 30, 20, 10 on successive cycles.
- Drain and shift together: i_drain=1 and i_y_shift=1 in one cycle -> o_y equals the local acc_next, not i_y. i_valid toggling while idle changes o_valid only, and acc holds.
